regfile_dump: RTL and testbench

Debug read-out engine for the LEGv8 processor. Sequentially reads every architectural register through a dedicated regfile read port and streams the values, preceded by a header word, over a valid/ready interface to a debug sink (UART/JTAG bridge or testbench monitor). It is the reading side of the register file's write port: writeback fills registers, this block drains a snapshot of them. It runs alongside the pipeline and never writes the register file.

---
 rtl/regdump_pkg.sv | 41 ++++
 rtl/regfile_dump.sv | 121 ++++++++++++
 tb/tb_regfile_dump.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// ============================================================================
//  Module      : regdump_pkg
//  Description : Shared definitions for the register-file dump engine:
//                FSM state encoding, stream header magic, register count
//                and the number of registers streamed per dump.
//  Config      : REGDUMP_SKIP_XZR_EN - when defined, X31 (XZR) is left out
//                of the dump (31 registers streamed instead of 32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regdump_pkg;

    // Architectural register file geometry
    localparam int NREGS = 32;
    localparam int RA_W  = $clog2(NREGS);

    // Number of registers carried by one dump
`ifdef REGDUMP_SKIP_XZR_EN
    localparam int COUNT = NREGS - 1;
`else
    localparam int COUNT = NREGS;
`endif

    // Index counter is one bit wider than the read address so that it can
    // reach COUNT without wrapping.
    localparam int IDX_W = RA_W + 1;

    // "REGD" in ASCII, placed in bits [63:32] of the header word
    localparam logic [31:0] REGDUMP_MAGIC = 32'h5245_4744;
    localparam logic [7:0]  COUNT_BYTE    = 8'(COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_dump.sv
// ============================================================================
//  Module      : regfile_dump
//  Description : Debug read-out engine. On start, streams a header word and
//                then every architectural register (read through a
//                dedicated regfile read port) over a valid/ready interface.
//  Config      : REGDUMP_SKIP_XZR_EN (see regdump_pkg) drops X31 from the
//                stream and lowers the header count byte to 31.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                start           - dump request, honoured only when idle
//                busy, done      - streaming in progress / end-of-dump pulse
//                ra, rd          - regfile read address / asynchronous data
//                out_valid/ready - stream handshake
//                out_data        - registered stream word
//                out_last        - final word marker (qualified by out_valid)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump
    import regdump_pkg::*;
#(
    parameter int N = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [RA_W-1:0] ra,
    input  logic [N-1:0]    rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic            out_last
);

    localparam logic [IDX_W-1:0] C_COUNT_IDX = IDX_W'(COUNT);
    localparam logic [RA_W-1:0]  C_LAST_RA   = RA_W'(COUNT - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE   = IDX_W'(1);

    state_e           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_data_q,  out_data_d;
    logic [N-1:0]     w_header;
    logic             w_handshake;

    // Header word: magic in [63:32], register count in [7:0], rest zero
    always_comb begin
        w_header        = '0;
        w_header[63:32] = REGDUMP_MAGIC;
        w_header[7:0]   = COUNT_BYTE;
    end

    // idx_q names the register to be sampled on the next handshake. While
    // the final register is held in out_data, idx_q equals COUNT; the read
    // address is pinned to the last streamed register then, so an index
    // beyond the dump range (X31 when it is skipped) is never presented.
    assign ra = (idx_q >= C_COUNT_IDX) ? C_LAST_RA : idx_q[RA_W-1:0];

    assign w_handshake = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    out_data_d  = w_header;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (w_handshake) begin
                    if (idx_q == C_COUNT_IDX) begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        // Zero-bubble: the next word is captured in the same
                        // cycle the current one is accepted.
                        out_data_d = rd;
                        idx_d      = idx_q + C_IDX_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_valid_q & (idx_q == C_COUNT_IDX);
    assign busy      = (state_q == SEND);
    assign done      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none

module tb_regfile_dump;

`ifdef REGDUMP_SKIP_XZR_EN
    localparam int EXP_COUNT = 31;
`else
    localparam int EXP_COUNT = 32;
`endif
    localparam logic [63:0] EXP_HDR = {32'h5245_4744, 24'h0, 8'(EXP_COUNT)};

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  ra;
    logic [63:0] rd, out_data;

    // Behavioural register file: asynchronous read, write at posedge,
    // X31 reads as zero.
    logic [63:0] rf [32];
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;

    always #5 clk = ~clk;

    assign rd = (ra == 5'd31) ? 64'd0 : rf[ra];

    always @(posedge clk) begin
        if (we && wa != 5'd31) rf[wa] <= wd;
    end

    regfile_dump #(.N(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ra        (ra),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: what the register file architecturally holds
    logic [63:0] model [32];
    logic [63:0] got_q [$];

    typedef struct {
        int          stall;       // 0 always ready, 1 random, 2 3-cycle stall on odd words
        int          init_rand;   // 0 Xi=i, 1 random contents
        int          wr_word;     // write issued in the cycle this word is accepted (-1 none)
        int          wr_reg;
        logic [63:0] wr_val;
        int          rst_word;    // reset while this word is held (-1 none)
        int          start_word;  // extra start pulse while this word is held (-1 none)
        int          exp_words;   // words expected to be accepted
        bit          exp_done;    // done pulse expected
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input int r);
        return (r == 31) ? 64'd0 : model[r];
    endfunction

    task automatic init_rf(input int rnd);
        for (int i = 0; i < 32; i++) begin
            logic [63:0] v;
            v = rnd ? {$urandom, $urandom} : 64'(i);
            @(negedge clk);
            we = 1'b1; wa = 5'(i); wd = v;
            model[i] = (i == 31) ? 64'd0 : v;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic run(input vec_t v);
        logic [63:0] exp_q [$];
        logic [63:0] prev_data;
        logic        prev_last;
        bit          prev_stall;
        bit          finished;
        bit          word_started;
        bit          start_used;
        bit          saw_done;
        int          stall_left;
        int          nw;
        int          cyc;
        logic        rdy;
        logic        hs;

        init_rf(v.init_rand);
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(EXP_HDR);
        nw = 0; cyc = 1; prev_stall = 0; finished = 0; word_started = 0;
        start_used = 0; saw_done = 0; stall_left = 0;
        prev_data = '0; prev_last = 1'b0;

        @(negedge clk);
        start = 1'b1; out_ready = 1'(($urandom));
        @(negedge clk);
        start = 1'b0;
        check("header_valid_latency", 64'(out_valid), 64'd1);

        for (int c = 0; c < 3000 && !finished; c++) begin
            if (!word_started) begin
                word_started = 1;
                stall_left   = (v.stall == 2 && (nw % 2) == 1) ? 3 : 0;
            end
            case (v.stall)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = (stall_left > 0) ? 1'b0 : 1'b1;
                default: rdy = 1'b1;
            endcase
            if (stall_left > 0) stall_left--;

            if (nw == v.rst_word) begin
                reset = 1'b1; out_ready = rdy; we = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_busy",      64'(busy),      64'd0);
                check("rst_done",      64'(done),      64'd0);
                check("rst_out_last",  64'(out_last),  64'd0);
                check("rst_out_data",  out_data,       64'd0);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (done) saw_done = 1;
                end
                finished = 1;
                break;
            end

            start = (nw == v.start_word && !start_used) ? 1'b1 : 1'b0;
            if (start) start_used = 1;
            out_ready = rdy;
            hs = out_valid & rdy;
            we = (hs && nw == v.wr_word);
            wa = 5'(v.wr_reg); wd = v.wr_val;

            check("busy_streaming", 64'(busy), 64'd1);
            check("valid_held", 64'(out_valid), 64'd1);
            check("out_last", 64'(out_last), 64'(nw == EXP_COUNT));
            if (nw < EXP_COUNT) check("ra_index", 64'(ra), 64'(nw));
`ifdef REGDUMP_SKIP_XZR_EN
            check("ra_never_31", 64'(ra == 5'd31), 64'd0);
`endif
            if (prev_stall) begin
                check("stall_data_stable", out_data, prev_data);
                check("stall_last_stable", 64'(out_last), 64'(prev_last));
            end

            if (hs) begin
                got_q.push_back(out_data);
                check($sformatf("word%0d", nw), out_data, exp_q[nw]);
                // Next register is sampled now; a write in this cycle lands after.
                if (nw < EXP_COUNT) exp_q.push_back(model_rd(nw));
                if (we && v.wr_reg != 31) model[v.wr_reg] = v.wr_val;
                nw++;
                word_started = 0;
                if (nw == EXP_COUNT + 1) finished = 1;
            end
            prev_stall = !rdy;
            prev_data  = out_data;
            prev_last  = out_last;

            @(negedge clk);
            cyc++;
            we = 1'b0; start = 1'b0;
        end

        if (!finished) begin
            check("timeout", 64'd0, 64'd1);
        end else if (v.rst_word < 0) begin
            out_ready = 1'b0;
            check("done_pulse", 64'(done), 64'd1);
            check("done_out_valid", 64'(out_valid), 64'd0);
            if (v.stall == 0) check("done_latency", 64'(cyc), 64'(EXP_COUNT + 2));
            saw_done = done;
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        check("words_accepted", 64'(nw), 64'(v.exp_words));
        check("done_seen", 64'(saw_done), 64'(v.exp_done));
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 0, -1, 0, 64'd0,      -1, -1, EXP_COUNT + 1, 1'b1};
        vecs[1] = '{2, 0, -1, 0, 64'd0,      -1, -1, EXP_COUNT + 1, 1'b1};
        vecs[2] = '{0, 0,  5, 5, 64'hDEAD,   -1, -1, EXP_COUNT + 1, 1'b1};
        vecs[3] = '{0, 0,  4, 5, 64'hDEAD,   -1, -1, EXP_COUNT + 1, 1'b1};
        vecs[4] = '{0, 0, -1, 0, 64'd0,      10, -1, 10,            1'b0};
        vecs[5] = '{0, 0, -1, 0, 64'd0,      -1,  7, EXP_COUNT + 1, 1'b1};
        vecs[6] = '{1, 1, 12, 20, {$urandom, $urandom}, -1, -1, EXP_COUNT + 1, 1'b1};
        vecs[7] = '{1, 1, -1, 0, 64'd0,      -1,  3, EXP_COUNT + 1, 1'b1};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        we = 1'b0; wa = '0; wd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_last",  64'(out_last),  64'd0);
        check("reset_out_data",  out_data,       64'd0);
        check("reset_busy",      64'(busy),      64'd0);
        check("reset_done",      64'(done),      64'd0);
        check("reset_ra",        64'(ra),        64'd0);
        reset = 1'b0;

        // Toggling ready with nothing to send must have no effect
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'(i & 1);
            @(negedge clk);
            check("idle_ready_toggle_valid", 64'(out_valid), 64'd0);
            check("idle_ready_toggle_done",  64'(done),      64'd0);
        end

        for (int i = 0; i < 8; i++) begin
            run(vecs[i]);
            if (i == 0) check("stream_last_value", got_q[EXP_COUNT],
                              (EXP_COUNT == 32) ? 64'd0 : 64'd30);
            if (i == 2) check("same_cycle_write_invisible", got_q[6], 64'd5);
            if (i == 3) check("earlier_write_visible",      got_q[6], 64'hDEAD);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
